core_dbg_master: RTL and testbench
==================================

Name: core_dbg_master

Overview:
Initiator end of the core debug interface (dbg_intf). Accepts single debug requests from a host-side bridge (UART/JTAG front end) over a valid/ready channel. Drives cmd/addr/data onto dbg_bus, waits for dut_done from the core debug responder, captures read data, and returns one response per request. Adds command screening and a timeout so the host never hangs on a dead responder.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles spent in BUSY or DRAIN before the transaction is aborted with an error; must be ≥ 4.

Ports:
clk  input  1  clock
rstn_i  input  1  asynchronous active-low reset
dbg_bus  interface  dbg_intf master side  drives cmd[7:0], addr[31:0], data_dbg_dut[31:0]; samples data_dut_dbg[31:0], dut_done
req_valid_i  input  1  host request valid
req_ready_o  output  1  request accepted when valid && ready
req_cmd_i  input  8  debug command: 1 halt, 2 resume, 3 read reg, 4 write reg, 5 read pc, 6 write pc
req_addr_i  input  32  register index; bits [4:0] used by the responder
req_data_i  input  32  write data for cmds 4 and 6
resp_valid_o  output  1  response valid
resp_ready_i  input  1  host accepts response
resp_data_o  output  32  read data for cmds 3 and 5; 0 otherwise
resp_err_o  output  1  1 = illegal command or timeout
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock `clk`; asynchronous active-low reset `rstn_i`.
- Reset state: state=IDLE, dbg_bus.cmd=0, addr=0, data_dbg_dut=0, resp_valid_o=0, resp_data_o=0, resp_err_o=0, busy_o=0, timeout counter=0, shadow data=0.
- Reset mid-transaction: abandons everything immediately. No response is produced. cmd=0 is the first post-reset value.
- States: IDLE, BUSY, DRAIN, RESP. req_ready_o=1 only in IDLE.
- IDLE:
  - On accept, register cmd/addr/data.
  - Legal cmd (1..6) -> BUSY.
  - Illegal cmd (0 or >6) -> RESP directly with err=1, data=0, no bus activity.
- BUSY:
  - dbg_bus.cmd/addr/data_dbg_dut are driven from registers; they are stable for the whole state.
  - Each cycle the shadow register samples data_dut_dbg.
  - On dut_done=1: resp_data = shadow value (sampled the cycle before done was seen) for cmds 3/5, else 0; err=0; go to DRAIN.
  - Counter increments each cycle. At TIMEOUT_CYCLES without done: err=1, data=0, go to DRAIN.
- DRAIN:
  - dbg_bus.cmd=0, addr=0, data=0.
  - Counter restarts at 0 on entry.
  - When dut_done=0 -> RESP. This guarantees the responder's registered done from this command cannot be mistaken for completion of the next one.
  - Timeout here: err forced to 1, go to RESP.
- RESP:
  - resp_valid_o=1; data/err held stable.
  - On resp_ready_i -> IDLE; resp_valid_o drops the next cycle.
  - A new request can be accepted at the earliest in the cycle after return to IDLE.
- Latency with a responder whose done is registered one cycle after cmd is seen:
  - Request accepted in cycle 0; cmd on the bus cycles 1..2.
  - dut_done seen in cycle 2; DRAIN cycles 3..4.
  - resp_valid_o high in cycle 5 (5 cycles).
  - Register accesses that need an extra halt cycle take 6.
- Response data and err come from registers, never combinational from the bus.
- Counter width: $clog2(TIMEOUT_CYCLES+1); saturates and does not wrap.
- dut_done asserted in IDLE or RESP is ignored.

Test Plan:
- Halt: req cmd=0x01 accepted cycle 0 -> cmd=0x01 on bus cycles 1-2, cmd=0 cycle 3, resp_valid cycle 5, err=0, data=0.
- Read reg: cmd=0x03, addr=5, responder returns 0xDEADBEEF -> resp_data_o=0xDEADBEEF, err=0; addr[4:0]=5 stable on the bus throughout BUSY.
- Write pc: cmd=0x06, data=0x0000_1000 -> data_dbg_dut=0x1000 held until done; resp data=0, err=0. Then read pc (cmd=0x05) against pc_i=0x1000 -> resp_data_o=0x1000.
- Illegal: cmd=0x00, then cmd=0x07 -> no bus activity; each gives a resp 1 cycle after accept with err=1. Hold resp_ready_i=0 for 3 cycles -> resp_valid_o, data and err stay stable.
- Timeout: TIMEOUT_CYCLES=8, responder never asserts done -> cmd dropped after 8 BUSY cycles, resp err=1, data=0. A subsequent halt completes normally.
- Reset: assert rstn_i low during BUSY of a read reg -> cmd=0, resp_valid_o=0, busy_o=0 immediately; no response after release; next request behaves as from reset.

Source files
------------

// File: rtl/core_dbg_master.sv
// Initiator side of the core debug bus: takes one host request, drives it onto the bus,
// waits for the responder's done, then returns one registered response.
//
// state | meaning
// IDLE  | ready for a host request, bus idle (cmd=0)
// BUSY  | command driven on the bus, waiting for done or timeout
// DRAIN | bus released, waiting for done to fall (or timeout)
// RESP  | response presented to host until accepted
module core_dbg_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn_i,

  output logic [7:0]  dbg_cmd,
  output logic [31:0] dbg_addr,
  output logic [31:0] dbg_data_dbg_dut,
  input  logic [31:0] dbg_data_dut_dbg,
  input  logic        dbg_dut_done,

  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_cmd_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,

  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] CMD_HALT   = 8'd1;
  localparam logic [7:0] CMD_WR_PC  = 8'd6;
  localparam logic [7:0] CMD_RD_REG = 8'd3;
  localparam logic [7:0] CMD_RD_PC  = 8'd5;

  logic [1:0]       state;
  logic [7:0]       cmd_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      shadow_q;
  logic [31:0]      resp_data_q;
  logic             resp_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             cmd_legal;
  logic             returns_data;
  logic             cnt_expired;
  logic [CNT_W-1:0] cnt_inc;

  assign cmd_legal    = (req_cmd_i >= CMD_HALT) && (req_cmd_i <= CMD_WR_PC);
  assign returns_data = (cmd_q == CMD_RD_REG) || (cmd_q == CMD_RD_PC);
  assign cnt_expired  = (cnt_q >= CNT_LAST);
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  assign req_ready_o      = (state == S_IDLE);
  assign busy_o           = (state != S_IDLE);
  assign resp_valid_o     = (state == S_RESP);
  assign resp_data_o      = resp_data_q;
  assign resp_err_o       = resp_err_q;
  assign dbg_cmd          = cmd_q;
  assign dbg_addr         = addr_q;
  assign dbg_data_dbg_dut = wdata_q;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= S_IDLE;
      cmd_q       <= 8'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      shadow_q    <= 32'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_q <= '0;
          if (req_valid_i) begin
            resp_data_q <= 32'h0;
            if (cmd_legal) begin
              cmd_q      <= req_cmd_i;
              addr_q     <= req_addr_i;
              wdata_q    <= req_data_i;
              resp_err_q <= 1'b0;
              state      <= S_BUSY;
            end else begin
              // screened out: answer immediately, bus never sees it
              resp_err_q <= 1'b1;
              state      <= S_RESP;
            end
          end
        end

        S_BUSY: begin
          shadow_q <= dbg_data_dut_dbg;
          if (dbg_dut_done || cnt_expired) begin
            resp_data_q <= (dbg_dut_done && returns_data) ? shadow_q : 32'h0;
            resp_err_q  <= !dbg_dut_done;
            cmd_q       <= 8'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= '0;
            state       <= S_DRAIN;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_DRAIN: begin
          // done must fall before the next command can be issued
          if (!dbg_dut_done) begin
            cnt_q <= '0;
            state <= S_RESP;
          end else if (cnt_expired) begin
            resp_err_q <= 1'b1;
            cnt_q      <= '0;
            state      <= S_RESP;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_RESP: begin
          if (resp_ready_i) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_dbg_master.sv
// Directed bench for core_dbg_master: behavioural responder with configurable done latency,
// dead and stuck-done modes; expected responses queued at issue and checked at handshake.
module tb_core_dbg_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  dbg_cmd;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_data_dbg_dut;
  logic [31:0] dbg_data_dut_dbg;
  logic        dbg_dut_done;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  core_dbg_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rstn_i           (rstn),
    .dbg_cmd          (dbg_cmd),
    .dbg_addr         (dbg_addr),
    .dbg_data_dbg_dut (dbg_data_dbg_dut),
    .dbg_data_dut_dbg (dbg_data_dut_dbg),
    .dbg_dut_done     (dbg_dut_done),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_cmd_i        (req_cmd),
    .req_addr_i       (req_addr),
    .req_data_i       (req_data),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_data_o      (resp_data),
    .resp_err_o       (resp_err),
    .busy_o           (busy)
  );

  // responder: done registered rsp_lat cycles after a nonzero cmd is seen
  int          rsp_lat = 1;
  logic        rsp_dead = 1'b0;
  logic        rsp_stuck = 1'b0;
  logic        rsp_done;
  int          rsp_cnt;
  logic [31:0] rsp_regs [32];
  logic [31:0] rsp_pc;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_done <= 1'b0;
      rsp_cnt  <= 0;
      rsp_pc   <= 32'h0;
      for (int i = 0; i < 32; i++) rsp_regs[i] <= 32'h0;
    end else if (dbg_cmd != 8'h0 && !rsp_dead) begin
      if (rsp_cnt >= rsp_lat - 1) begin
        rsp_done <= 1'b1;
        if (dbg_cmd == 8'd4) rsp_regs[dbg_addr[4:0]] <= dbg_data_dbg_dut;
        if (dbg_cmd == 8'd6) rsp_pc <= dbg_data_dbg_dut;
      end else begin
        rsp_cnt <= rsp_cnt + 1;
      end
    end else begin
      rsp_done <= 1'b0;
      rsp_cnt  <= 0;
    end
  end

  assign dbg_dut_done     = rsp_stuck | rsp_done;
  assign dbg_data_dut_dbg = (dbg_cmd == 8'd3) ? rsp_regs[dbg_addr[4:0]] :
                            (dbg_cmd == 8'd5) ? rsp_pc : 32'h0;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [32:0] sb_q [$];
  logic [7:0]  tr_cmd  [64];
  logic [31:0] tr_addr [64];
  logic [31:0] tr_data [64];
  int          last_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err, input int hold,
                         input int exp_lat, input string tag);
    logic [32:0] exp;
    logic [31:0] obs_data;
    logic        obs_err;
    int          lat;
    sb_q.push_back({exp_err, exp_data});
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_data  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 8'h0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tr_cmd[k]  = dbg_cmd;
      tr_addr[k] = dbg_addr;
      tr_data[k] = dbg_data_dbg_dut;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    last_lat = lat;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat < 0) begin
      void'(sb_q.pop_front());
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_data"}, resp_data, sb_q[0][31:0]);
      check({tag, "_hold_err"}, 32'(resp_err), 32'(sb_q[0][32]));
      @(negedge clk);
    end
    obs_data   = resp_data;
    obs_err    = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    exp = sb_q.pop_front();
    check({tag, "_resp_data"}, obs_data, exp[31:0]);
    check({tag, "_resp_err"}, 32'(obs_err), 32'(exp[32]));
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int on_bus;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_cmd    = 8'h0;
    req_addr   = 32'h0;
    req_data   = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'(dbg_cmd), 32'd0);
    check("rst_addr", dbg_addr, 32'd0);
    check("rst_wdata", dbg_data_dbg_dut, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    run_txn(8'd1, 32'h0, 32'h0, 32'h0, 1'b0, 0, 5, "halt");
    check("halt_cmd_c1", 32'(tr_cmd[1]), 32'd1);
    check("halt_cmd_c2", 32'(tr_cmd[2]), 32'd1);
    check("halt_cmd_c3", 32'(tr_cmd[3]), 32'd0);

    run_txn(8'd4, 32'd5, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 5, "wr_reg5");
    run_txn(8'd3, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 5, "rd_reg5");
    check("rd_reg5_addr_c1", tr_addr[1], 32'd5);
    check("rd_reg5_addr_c2", tr_addr[2], 32'd5);
    check("rd_reg5_cmd_c2", 32'(tr_cmd[2]), 32'd3);

    run_txn(8'd6, 32'h0, 32'h0000_1000, 32'h0, 1'b0, 0, 5, "wr_pc");
    check("wr_pc_data_c1", tr_data[1], 32'h0000_1000);
    check("wr_pc_data_c2", tr_data[2], 32'h0000_1000);
    run_txn(8'd5, 32'h0, 32'h0, 32'h0000_1000, 1'b0, 0, 5, "rd_pc");

    run_txn(8'd0, 32'd3, 32'h5555_AAAA, 32'h0, 1'b1, 3, 1, "illegal0");
    check("illegal0_no_bus", 32'(tr_cmd[1]), 32'd0);
    run_txn(8'd7, 32'h1F, 32'hFFFF_FFFF, 32'h0, 1'b1, 3, 1, "illegal7");
    check("illegal7_no_bus", 32'(tr_cmd[1]), 32'd0);
    check("illegal7_no_wdata", tr_data[1], 32'd0);

    rsp_lat = 2;
    run_txn(8'd4, 32'd9, 32'h1234_5678, 32'h0, 1'b0, 0, 6, "wr_reg9_slow");
    run_txn(8'd3, 32'd9, 32'h0, 32'h1234_5678, 1'b0, 2, 6, "rd_reg9_slow");
    check("rd_reg9_addr_c3", tr_addr[3], 32'd9);
    rsp_lat = 1;

    rsp_dead = 1'b1;
    run_txn(8'd3, 32'd5, 32'h0, 32'h0, 1'b1, 0, TO + 2, "timeout_busy");
    on_bus = 0;
    for (int k = 1; k < TO + 2; k++) if (tr_cmd[k] != 8'h0) on_bus++;
    check("timeout_busy_cycles", 32'(on_bus), 32'(TO));
    rsp_dead = 1'b0;
    run_txn(8'd1, 32'h0, 32'h0, 32'h0, 1'b0, 0, 5, "halt_after_to");

    @(negedge clk);
    rsp_stuck = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || resp_valid) bad++;
    end
    check("idle_done_ignored", 32'(bad), 32'd0);
    run_txn(8'd1, 32'h0, 32'h0, 32'h0, 1'b1, 0, TO + 2, "timeout_drain");
    rsp_stuck = 1'b0;
    run_txn(8'd1, 32'h0, 32'h0, 32'h0, 1'b0, 0, 5, "halt_after_drain_to");

    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = 8'd3;
    req_addr  = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 8'h0;
    req_addr  = 32'h0;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("abort_cmd", 32'(dbg_cmd), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid || busy) bad++;
    end
    check("abort_no_resp", 32'(bad), 32'd0);
    run_txn(8'd1, 32'h0, 32'h0, 32'h0, 1'b0, 0, 5, "halt_after_abort");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
